// File: rtl/topk_merge_e2.sv
`default_nettype none
// ============================================================================
//  Module   : topk_merge_e2
//  Purpose  : Second-stage top-5 merger. Each accepted bundle holds five
//             low-half and five high-half candidates. The bundle is folded into
//             a running global top-5 over MERGE0..MERGE4. On the bundle flagged
//             last, the final list is published, tagged with batch and lane.
//  Ports    : sys_clk / sys_rst_n (sync, active-low) / sorter_clr (sync clear)
//             E1L_sorter_out0..4, E1H_sorter_out0..4 : {lane, value} candidates
//             E1_sort_en, E1_last_sort, E1_index_counter : bundle strobe, tag
//             E2_out0..4 : {batch, lane, value}, E2_out0 largest
//             E2_out_vld_mask, E2_valid (pulse), E2_busy
//             overrun_err : sticky, only when E2_OVERRUN_ERR_EN is defined
//  Config   : `define E2_OVERRUN_ERR_EN adds the overrun_err port and flag
//  Revision : 1.0 - initial release
// ============================================================================
module topk_merge_e2 #(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 16,
    parameter int K           = 5
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst_n,
    input  logic                                  sorter_clr,
    input  logic [INDEX_WIDTH+DATA_WIDTH-1:0]     E1L_sorter_out0,
    input  logic [INDEX_WIDTH+DATA_WIDTH-1:0]     E1L_sorter_out1,
    input  logic [INDEX_WIDTH+DATA_WIDTH-1:0]     E1L_sorter_out2,
    input  logic [INDEX_WIDTH+DATA_WIDTH-1:0]     E1L_sorter_out3,
    input  logic [INDEX_WIDTH+DATA_WIDTH-1:0]     E1L_sorter_out4,
    input  logic [INDEX_WIDTH+DATA_WIDTH-1:0]     E1H_sorter_out0,
    input  logic [INDEX_WIDTH+DATA_WIDTH-1:0]     E1H_sorter_out1,
    input  logic [INDEX_WIDTH+DATA_WIDTH-1:0]     E1H_sorter_out2,
    input  logic [INDEX_WIDTH+DATA_WIDTH-1:0]     E1H_sorter_out3,
    input  logic [INDEX_WIDTH+DATA_WIDTH-1:0]     E1H_sorter_out4,
    input  logic                                  E1_sort_en,
    input  logic                                  E1_last_sort,
    input  logic [INDEX_WIDTH-1:0]                E1_index_counter,
    output logic [2*INDEX_WIDTH+DATA_WIDTH-1:0]   E2_out0,
    output logic [2*INDEX_WIDTH+DATA_WIDTH-1:0]   E2_out1,
    output logic [2*INDEX_WIDTH+DATA_WIDTH-1:0]   E2_out2,
    output logic [2*INDEX_WIDTH+DATA_WIDTH-1:0]   E2_out3,
    output logic [2*INDEX_WIDTH+DATA_WIDTH-1:0]   E2_out4,
    output logic [K-1:0]                          E2_out_vld_mask,
    output logic                                  E2_valid,
    output logic                                  E2_busy
`ifdef E2_OVERRUN_ERR_EN
    ,
    output logic                                  overrun_err
`endif
);

    localparam int C_ENT_W   = 2*INDEX_WIDTH + DATA_WIDTH;
    localparam int C_SLOTS   = 3*K;
    localparam int C_SLOT_IW = $clog2(C_SLOTS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MERGE0 = 3'd1,
        S_MERGE1 = 3'd2,
        S_MERGE2 = 3'd3,
        S_MERGE3 = 3'd4,
        S_MERGE4 = 3'd5
    } state_t;

    state_t                         state_q, state_d;
    // Pool slots: 0..K-1 running list, K..2K-1 low half, 2K..3K-1 high half
    logic [C_ENT_W-1:0]             slot_q [C_SLOTS];
    logic [C_ENT_W-1:0]             slot_d [C_SLOTS];
    logic [C_SLOTS-1:0]             slot_vld_q, slot_vld_d;
    logic [C_ENT_W-1:0]             new_q [K];
    logic [C_ENT_W-1:0]             new_d [K];
    logic [K-1:0]                   new_vld_q, new_vld_d;
    logic                           last_q, last_d;
    logic [C_ENT_W-1:0]             out_q [K];
    logic [C_ENT_W-1:0]             out_d [K];
    logic [K-1:0]                   mask_q, mask_d;
    logic                           valid_q, valid_d;

    logic [INDEX_WIDTH+DATA_WIDTH-1:0] w_l [K];
    logic [INDEX_WIDTH+DATA_WIDTH-1:0] w_h [K];

    logic                           win_found;
    logic [C_SLOT_IW-1:0]           win_idx;
    logic signed [DATA_WIDTH-1:0]   win_val;
    logic [C_ENT_W-1:0]             win_ent;
    logic [2:0]                     merge_idx;
    logic [C_ENT_W-1:0]             fin_ent [K];
    logic [K-1:0]                   fin_vld;

    assign w_l[0] = E1L_sorter_out0;
    assign w_l[1] = E1L_sorter_out1;
    assign w_l[2] = E1L_sorter_out2;
    assign w_l[3] = E1L_sorter_out3;
    assign w_l[4] = E1L_sorter_out4;
    assign w_h[0] = E1H_sorter_out0;
    assign w_h[1] = E1H_sorter_out1;
    assign w_h[2] = E1H_sorter_out2;
    assign w_h[3] = E1H_sorter_out3;
    assign w_h[4] = E1H_sorter_out4;

    // Max over valid slots; strict '>' keeps the lowest slot on ties, and
    // validity (not the 0x80 sentinel) decides participation.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_val   = '0;
        for (int s = 0; s < C_SLOTS; s++) begin
            if (slot_vld_q[s] &&
                (!win_found || $signed(slot_q[s][DATA_WIDTH-1:0]) > win_val)) begin
                win_found = 1'b1;
                win_idx   = C_SLOT_IW'(s);
                win_val   = slot_q[s][DATA_WIDTH-1:0];
            end
        end
        win_ent = win_found ? slot_q[win_idx] : '0;
    end

    always_comb begin
        case (state_q)
            S_MERGE1: merge_idx = 3'd1;
            S_MERGE2: merge_idx = 3'd2;
            S_MERGE3: merge_idx = 3'd3;
            S_MERGE4: merge_idx = 3'd4;
            default:  merge_idx = 3'd0;
        endcase
    end

    // Completed list at the end of MERGE4: entries 0..3 are already
    // registered, entry 4 is this cycle's winner.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            fin_ent[k] = new_q[k];
            fin_vld[k] = new_vld_q[k];
        end
        fin_ent[K-1] = win_ent;
        fin_vld[K-1] = win_found;
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        slot_vld_d = slot_vld_q;
        new_d      = new_q;
        new_vld_d  = new_vld_q;
        last_d     = last_q;
        out_d      = out_q;
        mask_d     = mask_q;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (E1_sort_en) begin
                    for (int k = 0; k < K; k++) begin
                        slot_d[K+k]       = {E1_index_counter, w_l[k]};
                        slot_d[2*K+k]     = {E1_index_counter, w_h[k]};
                        slot_vld_d[K+k]   = 1'b1;
                        slot_vld_d[2*K+k] = 1'b1;
                    end
                    last_d  = E1_last_sort;
                    state_d = S_MERGE0;
                end
            end
            S_MERGE0: state_d = S_MERGE1;
            S_MERGE1: state_d = S_MERGE2;
            S_MERGE2: state_d = S_MERGE3;
            S_MERGE3: state_d = S_MERGE4;
            default:  state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            new_d[merge_idx]     = win_ent;
            new_vld_d[merge_idx] = win_found;
            if (win_found) begin
                slot_vld_d[win_idx] = 1'b0;
            end
            if (state_q == S_MERGE4) begin
                for (int k = 0; k < K; k++) begin
                    slot_d[k]           = fin_ent[k];
                    slot_vld_d[k]       = fin_vld[k];
                    slot_vld_d[K+k]     = 1'b0;
                    slot_vld_d[2*K+k]   = 1'b0;
                end
                if (last_q) begin
                    for (int k = 0; k < K; k++) begin
                        out_d[k]      = fin_ent[k];
                        slot_vld_d[k] = 1'b0;
                    end
                    mask_d  = fin_vld;
                    valid_d = 1'b1;
                end
            end
        end
    end

`ifdef E2_OVERRUN_ERR_EN
    logic ovr_q, ovr_d;
    assign ovr_d       = ovr_q | (E1_sort_en && (state_q != S_IDLE));
    assign overrun_err = ovr_q;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || sorter_clr) begin
            state_q    <= S_IDLE;
            slot_vld_q <= '0;
            new_vld_q  <= '0;
            last_q     <= 1'b0;
            mask_q     <= '0;
            valid_q    <= 1'b0;
            for (int s = 0; s < C_SLOTS; s++) slot_q[s] <= '0;
            for (int k = 0; k < K; k++) begin
                new_q[k] <= '0;
                out_q[k] <= '0;
            end
`ifdef E2_OVERRUN_ERR_EN
            ovr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            slot_vld_q <= slot_vld_d;
            new_q      <= new_d;
            new_vld_q  <= new_vld_d;
            last_q     <= last_d;
            out_q      <= out_d;
            mask_q     <= mask_d;
            valid_q    <= valid_d;
`ifdef E2_OVERRUN_ERR_EN
            ovr_q      <= ovr_d;
`endif
        end
    end

    assign E2_out0         = out_q[0];
    assign E2_out1         = out_q[1];
    assign E2_out2         = out_q[2];
    assign E2_out3         = out_q[3];
    assign E2_out4         = out_q[4];
    assign E2_out_vld_mask = mask_q;
    assign E2_valid        = valid_q;
    assign E2_busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_topk_merge_e2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_topk_merge_e2
//  Purpose  : Self-checking bench for topk_merge_e2: table of directed
//             bundles, hand-written clear/reset/overlap sequences and random
//             bundles checked against a sort-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_topk_merge_e2;

    typedef logic [39:0] ent_t;
    typedef struct {
        logic [4:0][23:0] l;
        logic [4:0][23:0] h;
        logic [15:0]      batch;
        logic             last;
        logic [4:0][39:0] exp_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic en = 1'b0;
    logic last = 1'b0;
    logic [15:0] idx = '0;
    logic [4:0][23:0] l_in;
    logic [4:0][23:0] h_in;
    logic [39:0] o0, o1, o2, o3, o4;
    logic [4:0]  mask;
    logic        vld, busy;
`ifdef E2_OVERRUN_ERR_EN
    logic        ovr;
`endif

    int checks = 0;
    int errors = 0;
    ent_t run_q[$];
    logic [4:0][39:0] model_exp;
    vec_t tbl[4];

    always #5 clk = ~clk;

    topk_merge_e2 dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .sorter_clr(clr),
        .E1L_sorter_out0(l_in[0]), .E1L_sorter_out1(l_in[1]), .E1L_sorter_out2(l_in[2]),
        .E1L_sorter_out3(l_in[3]), .E1L_sorter_out4(l_in[4]),
        .E1H_sorter_out0(h_in[0]), .E1H_sorter_out1(h_in[1]), .E1H_sorter_out2(h_in[2]),
        .E1H_sorter_out3(h_in[3]), .E1H_sorter_out4(h_in[4]),
        .E1_sort_en(en), .E1_last_sort(last), .E1_index_counter(idx),
        .E2_out0(o0), .E2_out1(o1), .E2_out2(o2), .E2_out3(o3), .E2_out4(o4),
        .E2_out_vld_mask(mask), .E2_valid(vld), .E2_busy(busy)
`ifdef E2_OVERRUN_ERR_EN
        , .overrun_err(ovr)
`endif
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: stable descending sort of running list followed by L then H.
    task automatic model_apply(input logic [4:0][23:0] l, input logic [4:0][23:0] h,
                               input logic [15:0] b, input logic lst);
        ent_t cand[$];
        ent_t srt[$];
        cand = run_q;
        for (int k = 0; k < 5; k++) cand.push_back({b, l[k]});
        for (int k = 0; k < 5; k++) cand.push_back({b, h[k]});
        foreach (cand[i]) begin
            int pos;
            bit found;
            logic signed [7:0] cv, sv;
            pos = srt.size();
            found = 1'b0;
            cv = cand[i][7:0];
            for (int j = 0; j < srt.size(); j++) begin
                sv = srt[j][7:0];
                if (!found && sv < cv) begin
                    pos = j;
                    found = 1'b1;
                end
            end
            srt.insert(pos, cand[i]);
        end
        for (int k = 0; k < 5; k++) model_exp[k] = srt[k];
        run_q.delete();
        if (!lst) for (int k = 0; k < 5; k++) run_q.push_back(srt[k]);
    endtask

    task automatic chk_outs(input string tag, input logic [4:0][39:0] e);
        logic [4:0][39:0] act;
        act = {o4, o3, o2, o1, o0};
        for (int k = 0; k < 5; k++) chk($sformatf("%s_out%0d", tag, k), act[k], e[k]);
        chk({tag, "_mask"}, mask, 5'h1f);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, vld, 0);
        chk({tag, "_mask"}, mask, 0);
        chk({tag, "_outs"}, {o0, o1, o2, o3, o4} == '0, 1);
    endtask

    // Called right after a negedge; returns at the negedge of cycle T+1.
    task automatic issue(input logic [4:0][23:0] l, input logic [4:0][23:0] h,
                         input logic [15:0] b, input logic lst, input bit accept);
        l_in = l; h_in = h; idx = b; last = lst; en = 1'b1;
        @(posedge clk);
        if (accept) model_apply(l, h, b, lst);
        @(negedge clk);
        en = 1'b0;
    endtask

    // Checks busy over T+1..T+5 and the result in T+6 (returns at that negedge).
    task automatic wait_result(input bit exp_valid, input int drop_at,
                               input logic [4:0][39:0] e);
        for (int c = 1; c <= 5; c++) begin
            en = (c == drop_at);
            chk($sformatf("busy_c%0d", c), busy, 1);
            chk($sformatf("early_valid_c%0d", c), vld, 0);
            @(negedge clk);
        end
        en = 1'b0;
        chk("valid_T6", vld, exp_valid);
        chk("busy_T6", busy, 0);
        if (exp_valid) chk_outs("res", e);
    endtask

    function automatic logic [7:0] rval();
        return ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(126, 130));
    endfunction

    task automatic rand_bundle(output logic [4:0][23:0] l, output logic [4:0][23:0] h);
        for (int k = 0; k < 5; k++) begin
            l[k] = {16'($urandom), rval()};
            h[k] = {16'($urandom), rval()};
        end
    endtask

    initial begin
        logic [4:0][23:0] rl, rh;
        logic [15:0] rb;
        logic rlast;

        l_in = '0; h_in = '0;
        for (int k = 0; k < 5; k++) begin
            tbl[0].l[k] = {16'(k), 8'(10 - k)};
            tbl[0].h[k] = {16'(16 + k), (k == 0) ? 8'd20 : 8'd1};
            tbl[1].l[k] = {16'(k), 8'hFB};
            tbl[1].h[k] = {16'(16 + k), 8'hFB};
            tbl[2].l[k] = {16'(k), (k == 0) ? 8'hFC : 8'h9C};
            tbl[2].h[k] = {16'(16 + k), 8'h9C};
            tbl[3].l[k] = {16'(k), 8'h80};
            tbl[3].h[k] = {16'(16 + k), 8'h80};
            tbl[1].exp_out[k] = '0;
            tbl[3].exp_out[k] = {16'd7, 16'(k), 8'h80};
            if (k > 0) begin
                tbl[0].exp_out[k] = {16'd3, 16'(k - 1), 8'(11 - k)};
                tbl[2].exp_out[k] = {16'd1, 16'(k - 1), 8'hFB};
            end
        end
        tbl[0].exp_out[0] = {16'd3, 16'h10, 8'd20};
        tbl[2].exp_out[0] = {16'd2, 16'd0, 8'hFC};
        tbl[0].batch = 16'd3; tbl[0].last = 1'b1;
        tbl[1].batch = 16'd1; tbl[1].last = 1'b0;
        tbl[2].batch = 16'd2; tbl[2].last = 1'b1;
        tbl[3].batch = 16'd7; tbl[3].last = 1'b1;

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            issue(tbl[i].l, tbl[i].h, tbl[i].batch, tbl[i].last, 1'b1);
            wait_result(tbl[i].last, 0, tbl[i].exp_out);
            if (tbl[i].last) begin
                @(negedge clk);
                chk($sformatf("tbl%0d_pulse_end", i), vld, 0);
                chk($sformatf("tbl%0d_hold", i), o0, tbl[i].exp_out[0]);
            end
        end

        // Back-to-back at 6-cycle spacing, with an extra strobe dropped at T+3
        rand_bundle(rl, rh);
        issue(rl, rh, 16'h0A, 1'b0, 1'b1);
        wait_result(1'b0, 0, model_exp);
        rand_bundle(rl, rh);
        issue(rl, rh, 16'h0B, 1'b1, 1'b1);
        wait_result(1'b1, 3, model_exp);
`ifdef E2_OVERRUN_ERR_EN
        chk("overrun_set", ovr, 1);
`endif

        // Strobe coincident with clear is ignored
        en = 1'b1; clr = 1'b1;
        @(negedge clk);
        en = 1'b0; clr = 1'b0;
        chk_zero("clr_strobe");
`ifdef E2_OVERRUN_ERR_EN
        chk("overrun_cleared", ovr, 0);
`endif

        // Clear during MERGE2 abandons the merge and flushes history
        rand_bundle(rl, rh);
        issue(rl, rh, 16'h20, 1'b0, 1'b1);
        wait_result(1'b0, 0, model_exp);
        rand_bundle(rl, rh);
        issue(rl, rh, 16'h21, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        run_q.delete();
        chk_zero("mid_clr");
        for (int c = 0; c < 6; c++) begin
            chk("no_valid_after_clr", vld, 0);
            @(negedge clk);
        end
        rand_bundle(rl, rh);
        issue(rl, rh, 16'h22, 1'b1, 1'b1);
        wait_result(1'b1, 0, model_exp);

        // Reset pulse during MERGE3
        rand_bundle(rl, rh);
        issue(rl, rh, 16'h30, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_q.delete();
        chk_zero("mid_reset");

        // Random bundles with random idle gaps
        for (int r = 0; r < 40; r++) begin
            rand_bundle(rl, rh);
            rb = 16'($urandom);
            rlast = ($urandom_range(0, 3) == 0) || (r == 39);
            issue(rl, rh, rb, rlast, 1'b1);
            wait_result(rlast, 0, model_exp);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
